sum_accumulator: RTL and testbench

- Downstream consumer of the 8-bit combinational adder.
- Accepts a stream of adder sums over a valid/ready handshake and accumulates a programmable-length block of them into a wide accumulator.
- Presents the block total, beat count and a sticky overflow flag on a registered valid/ready output.
- Used to check adder results in bulk and as the reduction stage of the arithmetic datapath.

---
 rtl/sum_accumulator_if.sv | 32 +++
 rtl/sum_accumulator.sv | 137 +++++++++++++
 tb/tb_sum_accumulator.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - beat input stream and block result stream of sum_accumulator
//
// Purpose: groups the two handshaked paths of the accumulator.
// Ports (signals):
//   in_data/in_valid/in_ready           incoming adder sums, producer -> accumulator
//   out_sum/out_count/out_ovf/out_valid block result, accumulator -> consumer
//   out_ready                           consumer accepts the result
// Modports: master = producer/consumer side (bench), slave = accumulator.
interface sum_accumulator_if #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 8,
    parameter int ACC_W   = 16
);
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [COUNT_W-1:0] out_count;
    logic               out_ovf;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_count, out_ovf, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sum, out_count, out_ovf, out_valid
    );
endinterface

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates a programmable-length block of adder sums
//
// Purpose: on start, sums len unsigned beats into an ACC_W-bit accumulator and
// presents total, beat count and sticky carry-out flag as one registered result.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   start  begin a block (honoured only when idle)
//   len    block length in beats, latched with start; 0 gives an empty result
//   busy   high whenever a block is in progress or its result is pending
//   bus    slave side of sum_accumulator_if (beat stream in, result out)
module sum_accumulator #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 8,
    parameter int ACC_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    output logic               busy,
    sum_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] len_q, len_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   res_sum_q, res_sum_d;
    logic [COUNT_W-1:0] res_count_q, res_count_d;
    logic               res_ovf_q, res_ovf_d;

    // One extra bit on the left captures the carry out of the accumulator.
    logic [ACC_W:0]     acc_ext;
    logic [COUNT_W-1:0] count_inc;

    assign acc_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, bus.in_data};
    assign count_inc = count_q + COUNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            res_sum_q   <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            res_sum_q   <= res_sum_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        res_sum_d   = res_sum_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (len != '0) begin
                        len_d   = len;
                        state_d = ACCUM;
                    end else begin
                        // Empty block: publish an all-zero result straight away.
                        res_sum_d   = '0;
                        res_count_d = '0;
                        res_ovf_d   = 1'b0;
                        state_d     = DONE;
                    end
                end
            end

            ACCUM: begin
                // in_ready is high for the whole of ACCUM, so in_valid alone accepts.
                if (bus.in_valid) begin
                    acc_d   = acc_ext[ACC_W-1:0];
                    ovf_d   = ovf_q | acc_ext[ACC_W];
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        // Result registers load on the final beat so out_valid
                        // and the data appear together one cycle later.
                        res_sum_d   = acc_ext[ACC_W-1:0];
                        res_count_d = count_inc;
                        res_ovf_d   = ovf_q | acc_ext[ACC_W];
                        state_d     = DONE;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the state register only.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign busy          = (state_q != IDLE);

    // Result registers hold the last block's values until the next block completes.
    assign bus.out_sum   = res_sum_q;
    assign bus.out_count = res_count_q;
    assign bus.out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - scoreboard testbench for sum_accumulator
module tb_sum_accumulator;

    localparam int DATA_W  = 8;
    localparam int COUNT_W = 8;
    localparam int ACC_W   = 16;
    localparam int SACC_W  = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [COUNT_W-1:0] len;
    logic               busy;

    logic               sstart;
    logic [COUNT_W-1:0] slen;
    logic               sbusy;

    sum_accumulator_if #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .ACC_W(ACC_W))  bus ();
    sum_accumulator_if #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .ACC_W(SACC_W)) sbus ();

    sum_accumulator #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .len   (len),
        .busy  (busy),
        .bus   (bus)
    );

    sum_accumulator #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .ACC_W(SACC_W)) dut_small (
        .clk   (clk),
        .reset (reset),
        .start (sstart),
        .len   (slen),
        .busy  (sbusy),
        .bus   (sbus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ACC_W-1:0]   sum;
        logic [COUNT_W-1:0] count;
        logic               ovf;
    } result_t;

    result_t exp_q[$];
    result_t mon_e;
    result_t push_r;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ACC_W-1:0] m_sum;
    logic             m_ovf;
    int               m_cnt;
    int               m_len;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        push_r.sum   = m_sum;
        push_r.count = COUNT_W'(m_cnt);
        push_r.ovf   = m_ovf;
        exp_q.push_back(push_r);
    endtask

    task automatic blk_start(input int l);
        start = 1'b1;
        len   = COUNT_W'(l);
        m_sum = '0;
        m_ovf = 1'b0;
        m_cnt = 0;
        m_len = l;
        tick();
        start = 1'b0;
        if (l == 0) push_expected();
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d);
        int n;
        logic [ACC_W:0] t;
        n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            check_eq("beat_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            t = {1'b0, m_sum} + (ACC_W + 1)'(d);
            m_sum = t[ACC_W-1:0];
            m_ovf = m_ovf | t[ACC_W];
            m_cnt++;
            if (m_cnt == m_len) push_expected();
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            tick();
            n++;
        end
        check_eq("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    // Result handshake completes at the next rising edge; compare once per result.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("sb_sum",   32'(bus.out_sum),   32'(mon_e.sum));
                check_eq("sb_count", 32'(bus.out_count), 32'(mon_e.count));
                check_eq("sb_ovf",   32'(bus.out_ovf),   32'(mon_e.ovf));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra, rb, rs;

        reset         = 1'b0;
        start         = 1'b0;
        len           = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        sstart        = 1'b0;
        slen          = '0;
        sbus.in_valid = 1'b0;
        sbus.in_data  = '0;
        sbus.out_ready = 1'b1;
        m_sum = '0;
        m_ovf = 1'b0;
        m_cnt = 0;
        m_len = 0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check_eq("rst_out_sum",   32'(bus.out_sum),   32'd0);
        check_eq("rst_out_count", 32'(bus.out_count), 32'd0);
        check_eq("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        check_eq("rst_busy",      32'(busy),          32'd0);
        reset = 1'b1;
        tick();

        // Basic block, back-to-back beats.
        blk_start(4);
        send_beat(8'h10);
        send_beat(8'h20);
        send_beat(8'h30);
        check_eq("basic_early_valid", 32'(bus.out_valid), 32'd0);
        send_beat(8'h40);
        check_eq("basic_latency", 32'(bus.out_valid), 32'd1);
        tick();
        check_eq("basic_one_cycle", 32'(bus.out_valid), 32'd0);
        wait_drain();

        // Zero-length block.
        blk_start(0);
        check_eq("zero_valid",    32'(bus.out_valid), 32'd1);
        check_eq("zero_in_ready", 32'(bus.in_ready),  32'd0);
        tick();
        check_eq("zero_busy_low", 32'(busy), 32'd0);
        wait_drain();

        // Full scale with default widths: no overflow.
        blk_start(255);
        for (int i = 0; i < 255; i++) send_beat(8'hFF);
        wait_drain();

        // Gaps between beats and a start pulse during ACCUM.
        blk_start(3);
        send_beat(8'd1);
        tick();
        start = 1'b1;
        len   = 8'd7;
        tick();
        start = 1'b0;
        send_beat(8'd2);
        repeat (2) tick();
        send_beat(8'd3);
        wait_drain();

        // Hold result under backpressure; start and in_valid ignored in DONE.
        bus.out_ready = 1'b0;
        blk_start(2);
        send_beat(8'd7);
        send_beat(8'd9);
        for (int i = 0; i < 5; i++) begin
            start        = 1'b1;
            len          = 8'd3;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h80;
            tick();
            check_eq("hold_valid",    32'(bus.out_valid), 32'd1);
            check_eq("hold_sum",      32'(bus.out_sum),   32'd16);
            check_eq("hold_count",    32'(bus.out_count), 32'd2);
            check_eq("hold_in_ready", 32'(bus.in_ready),  32'd0);
            check_eq("hold_busy",     32'(busy),          32'd1);
        end
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset mid-block: partial block is discarded.
        blk_start(4);
        send_beat(8'h55);
        send_beat(8'h66);
        reset = 1'b0;
        #1;
        check_eq("mrst_out_sum",   32'(bus.out_sum),   32'd0);
        check_eq("mrst_out_count", 32'(bus.out_count), 32'd0);
        check_eq("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mrst_in_ready",  32'(bus.in_ready),  32'd0);
        check_eq("mrst_busy",      32'(busy),          32'd0);
        tick();
        reset = 1'b1;
        tick();
        blk_start(2);
        send_beat(8'h01);
        send_beat(8'h02);
        wait_drain();

        // Random adder-driven blocks with random input gaps.
        for (int blk = 0; blk < 64; blk++) begin
            blk_start(16);
            for (int i = 0; i < 16; i++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rs = ra + rb;
                if ($urandom_range(0, 3) == 0) tick();
                send_beat(rs);
            end
            wait_drain();
        end

        // Narrow accumulator: 5 x 0xFF wraps 10 bits.
        sstart = 1'b1;
        slen   = 8'd5;
        tick();
        sstart = 1'b0;
        sbus.in_valid = 1'b1;
        sbus.in_data  = 8'hFF;
        repeat (5) tick();
        sbus.in_valid = 1'b0;
        check_eq("small_valid", 32'(sbus.out_valid), 32'd1);
        check_eq("small_sum",   32'(sbus.out_sum),   32'h0FB);
        check_eq("small_count", 32'(sbus.out_count), 32'd5);
        check_eq("small_ovf",   32'(sbus.out_ovf),   32'd1);
        tick();
        check_eq("small_done",  32'(sbus.out_valid), 32'd0);
        check_eq("small_busy",  32'(sbusy),          32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
